// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS processing unit.
// FSM states, opcode/funct constants, ALU operations, instruction fields.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_t;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) ||
               (op == OP_LW)    || (op == OP_SW)   ||
               (op == OP_BEQ)   || (op == OP_BNE)  ||
               (op == OP_J)     || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the multi-cycle MIPS unit.
// 32-bit wrapping arithmetic, signed slt, shifts by shamt on b.
module mc_alu
    import mc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_op_t     alu_op,
    output logic [31:0] y
);

    // Select the result for the requested operation.
    always_comb begin
        y = '0;
        unique case (alu_op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL: y = b << shamt;
            ALU_SRL: y = b >> shamt;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mc_process_unit.sv
// Multi-cycle 32-bit MIPS processing unit with a unified memory port.
// Internal FSM, req/ready wait states, halt detection, debug reads.
module mc_process_unit
    import mc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]        HALT_OP  = 6'h3F
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halt,
    output logic [ADDR_W-1:0] pc_debug,
    output logic [31:0]       instruction_debug,
    output logic [2:0]        state_debug,
    input  logic [4:0]        dbg_sel,
    output logic [31:0]       dbg_data
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [31:0]       a_reg;
    logic [31:0]       b_reg;
    logic [31:0]       imm;
    logic [31:0]       alu_out;
    logic [31:0]       mdr;
    logic [31:0]       regs [32];

    instr_t            fi;
    logic              is_r, is_addi, is_lw, is_sw;
    logic              is_beq, is_bne, is_j, is_jal;
    logic              fn_alu, fn_jr;
    logic              c_ralu, c_jr, c_rbad, c_mem;
    logic              br_take;
    alu_op_t           alu_op;
    logic [31:0]       alu_b;
    logic [31:0]       alu_y;
    logic [31:0]       pc_ext;
    logic [31:0]       jt;
    logic [31:0]       br_off;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;

    assign fi      = instr_t'(ir);
    assign is_r    = fi.op == OP_RTYPE;
    assign is_addi = fi.op == OP_ADDI;
    assign is_lw   = fi.op == OP_LW;
    assign is_sw   = fi.op == OP_SW;
    assign is_beq  = fi.op == OP_BEQ;
    assign is_bne  = fi.op == OP_BNE;
    assign is_j    = fi.op == OP_J;
    assign is_jal  = fi.op == OP_JAL;

    assign fn_jr   = fi.funct == FN_JR;
    assign c_ralu  = is_r && fn_alu;
    assign c_jr    = is_r && fn_jr;
    assign c_rbad  = is_r && !fn_alu && !fn_jr;
    assign c_mem   = is_lw || is_sw;

    assign br_take = (is_beq && (a_reg == b_reg)) ||
                     (is_bne && (a_reg != b_reg));

    assign pc_ext  = 32'(pc);
    assign jt      = {pc_ext[31:28], ir[25:0], 2'b00};
    assign br_off  = imm << 2;
    assign alu_b   = is_r ? b_reg : imm;

    // Map R-type funct onto an ALU op; everything else adds.
    always_comb begin
        alu_op = ALU_ADD;
        fn_alu = 1'b0;
        if (is_r) begin
            unique case (fi.funct)
                FN_ADD: begin alu_op = ALU_ADD; fn_alu = 1'b1; end
                FN_SUB: begin alu_op = ALU_SUB; fn_alu = 1'b1; end
                FN_AND: begin alu_op = ALU_AND; fn_alu = 1'b1; end
                FN_OR:  begin alu_op = ALU_OR;  fn_alu = 1'b1; end
                FN_SLT: begin alu_op = ALU_SLT; fn_alu = 1'b1; end
                FN_SLL: begin alu_op = ALU_SLL; fn_alu = 1'b1; end
                FN_SRL: begin alu_op = ALU_SRL; fn_alu = 1'b1; end
                default: ;
            endcase
        end
    end

    mc_alu u_alu (
        .a      (a_reg),
        .b      (alu_b),
        .shamt  (fi.shamt),
        .alu_op (alu_op),
        .y      (alu_y)
    );

    // FSM state register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    // Next state and memory port drive; reset forces the port idle.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        we        = 1'b0;
        addr      = '0;
        wdata     = '0;
        unique case (state)
            S_FETCH: begin
                req  = 1'b1;
                addr = pc;
                if (mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (fi.op == HALT_OP || !op_supported(fi.op))
                    state_nxt = S_HALT;
                else
                    state_nxt = S_EXEC;
            end
            S_EXEC: begin
                unique case (1'b1)
                    c_ralu:  state_nxt = S_WB;
                    c_jr:    state_nxt = S_FETCH;
                    c_rbad:  state_nxt = S_HALT;
                    is_addi: state_nxt = S_WB;
                    c_mem:   state_nxt = S_MEM;
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                req   = 1'b1;
                we    = is_sw;
                addr  = alu_out[ADDR_W-1:0];
                wdata = is_sw ? b_reg : 32'd0;
                if (mem_ready) state_nxt = is_sw ? S_FETCH : S_WB;
            end
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
        if (Rst) begin
            req   = 1'b0;
            we    = 1'b0;
            addr  = '0;
            wdata = '0;
        end
    end

    // Datapath registers: PC, IR, operand latches, ALU result, MDR.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            imm     <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata;
                        pc <= pc + ADDR_W'(4);
                    end
                end
                S_DECODE: begin
                    a_reg <= regs[fi.rs];
                    b_reg <= regs[fi.rt];
                    imm   <= {{16{ir[15]}}, ir[15:0]};
                end
                S_EXEC: begin
                    if (c_ralu || is_addi || c_mem) alu_out <= alu_y;
                    if (c_jr)                       pc <= a_reg[ADDR_W-1:0];
                    if (br_take)                    pc <= pc + br_off[ADDR_W-1:0];
                    if (is_j || is_jal)             pc <= jt[ADDR_W-1:0];
                end
                S_MEM: begin
                    if (mem_ready && !is_sw) mdr <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // Register file write port: jal link in EXEC, results in WB.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (state == S_EXEC && is_jal) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_ext;
        end else if (state == S_WB) begin
            rf_we    = 1'b1;
            rf_waddr = is_r ? fi.rd : fi.rt;
            rf_wdata = is_lw ? mdr : alu_out;
        end
    end

    // Register file storage; $0 is never written.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    assign mem_req           = req;
    assign mem_we            = we;
    assign mem_addr          = {addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata         = wdata;
    assign halt              = state == S_HALT;
    assign pc_debug          = pc;
    assign instruction_debug = ir;
    assign state_debug       = state;
    assign dbg_data          = (dbg_sel == 5'd0) ? 32'd0 : regs[dbg_sel];

endmodule

// File: tb/tb_mc_process_unit.sv
// Directed bench for mc_process_unit with a wait-state memory model.
// Table of per-instruction expectations plus hand-written corner cases.
module tb_mc_process_unit;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        halt;
    logic [31:0] pc_debug;
    logic [31:0] instruction_debug;
    logic [2:0]  state_debug;
    logic [4:0]  dbg_sel = 5'd0;
    logic [31:0] dbg_data;

    int n_chk  = 0;
    int n_fail = 0;

    mc_process_unit dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ready         (mem_ready),
        .halt              (halt),
        .pc_debug          (pc_debug),
        .instruction_debug (instruction_debug),
        .state_debug       (state_debug),
        .dbg_sel           (dbg_sel),
        .dbg_data          (dbg_data)
    );

    always #5 Clk = ~Clk;

    // Memory model: program image, written-data overlay, wait counter.
    logic [31:0] prog [64];
    logic [31:0] dmem [64];
    bit          dval [64];
    int          waits = 0;
    int          wcnt  = 0;
    int          n_wr  = 0;
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;

    assign mem_ready = mem_req && (wcnt == waits);
    assign mem_rdata = dval[mem_addr[7:2]] ? dmem[mem_addr[7:2]]
                                           : prog[mem_addr[7:2]];

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wcnt <= 0;
        end else if (mem_req && !mem_ready) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
            if (mem_req && mem_we) begin
                dmem[mem_addr[7:2]] <= mem_wdata;
                dval[mem_addr[7:2]] <= 1'b1;
                last_wa <= mem_addr;
                last_wd <= mem_wdata;
                n_wr    <= n_wr + 1;
            end
        end
    end

    typedef struct {
        string       name;
        int          w;
        int          cyc;
        logic [31:0] pc;
        logic [4:0]  r;
        logic [31:0] rv;
        logic [31:0] ma;
        bit          isw;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(string nm, int w, int cyc,
                                logic [31:0] pc, logic [4:0] r,
                                logic [31:0] rv, logic [31:0] ma,
                                bit isw, logic [31:0] wd);
        vec_t v;
        v.name = nm; v.w = w; v.cyc = cyc; v.pc = pc; v.r = r;
        v.rv = rv; v.ma = ma; v.isw = isw; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic port_chk(input logic [31:0] fa, input logic [31:0] ma,
                            input bit isw, input logic [31:0] wd);
        if (state_debug == 3'd0) begin
            chk("fetch_req", mem_req, 1);
            chk("fetch_addr", mem_addr, fa);
            chk("fetch_we", mem_we, 0);
        end else if (state_debug == 3'd3) begin
            chk("mem_req", mem_req, 1);
            chk("mem_addr", mem_addr, ma);
            chk("mem_we", mem_we, isw);
            if (isw) chk("mem_wdata", mem_wdata, wd);
        end else begin
            chk("idle_req", mem_req, 0);
        end
    endtask

    // Runs one instruction from FETCH until the next FETCH or HALT.
    task automatic run_instr(input logic [31:0] fa, input logic [31:0] ma,
                             input bit isw, input logic [31:0] wd,
                             output int cyc);
        bit left;
        left = 0;
        cyc  = 0;
        port_chk(fa, ma, isw, wd);
        forever begin
            @(posedge Clk); #1;
            cyc++;
            if (state_debug != 3'd0) left = 1;
            else if (left) break;
            if (state_debug == 3'd5) break;
            port_chk(fa, ma, isw, wd);
            if (cyc > 60) begin
                n_chk++; n_fail++;
                $display("FAIL timeout: got %0d cycles expected <= 60", cyc);
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int bad;
        int wr0;
        logic [31:0] fa;

        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        prog[0]  = 32'h20020005;
        prog[1]  = 32'h2003FFFD;
        prog[2]  = 32'h00432020;
        prog[3]  = 32'h0062282A;
        prog[4]  = 32'h0C000010;
        prog[5]  = 32'hAC020008;
        prog[6]  = 32'h8C060008;
        prog[7]  = 32'h20E70001;
        prog[8]  = 32'h10E5FFFE;
        prog[9]  = 32'h14460005;
        prog[10] = 32'h20000007;
        prog[11] = 32'h00434822;
        prog[12] = 32'h00025100;
        prog[13] = 32'hFC000000;
        prog[16] = 32'h08000012;
        prog[18] = 32'h03E00008;

        tbl[0]  = mk("addi2",  0, 4, 32'h04,  2, 32'd5,        0, 0, 0);
        tbl[1]  = mk("addi3",  0, 4, 32'h08,  3, 32'hFFFFFFFD, 0, 0, 0);
        tbl[2]  = mk("add4",   0, 4, 32'h0C,  4, 32'd2,        0, 0, 0);
        tbl[3]  = mk("slt5",   0, 4, 32'h10,  5, 32'd1,        0, 0, 0);
        tbl[4]  = mk("jal",    0, 3, 32'h40, 31, 32'h14,       0, 0, 0);
        tbl[5]  = mk("j",      0, 3, 32'h48, 31, 32'h14,       0, 0, 0);
        tbl[6]  = mk("jr",     0, 3, 32'h14, 31, 32'h14,       0, 0, 0);
        tbl[7]  = mk("sw",     2, 8, 32'h18,  2, 32'd5,        8, 1, 5);
        tbl[8]  = mk("lw",     2, 9, 32'h1C,  6, 32'd5,        8, 0, 0);
        tbl[9]  = mk("addi7a", 0, 4, 32'h20,  7, 32'd1,        0, 0, 0);
        tbl[10] = mk("beq_t",  0, 3, 32'h1C,  7, 32'd1,        0, 0, 0);
        tbl[11] = mk("addi7b", 0, 4, 32'h20,  7, 32'd2,        0, 0, 0);
        tbl[12] = mk("beq_nt", 0, 3, 32'h24,  7, 32'd2,        0, 0, 0);
        tbl[13] = mk("bne_nt", 1, 4, 32'h28,  6, 32'd5,        0, 0, 0);
        tbl[14] = mk("addi0",  0, 4, 32'h2C,  0, 32'd0,        0, 0, 0);
        tbl[15] = mk("sub9",   0, 4, 32'h30,  9, 32'd8,        0, 0, 0);
        tbl[16] = mk("sll10",  0, 4, 32'h34, 10, 32'h50,       0, 0, 0);

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_halt", halt, 0);
        chk("rst_state", state_debug, 0);
        chk("rst_pc", pc_debug, 0);
        chk("rst_ir", instruction_debug, 0);
        Rst = 1'b0;
        #1;
        chk("rel_req", mem_req, 1);
        chk("rel_addr", mem_addr, 0);
        chk("rel_state", state_debug, 0);

        // Main program, one table row per instruction
        for (int i = 0; i < 17; i++) begin
            fa = (i == 0) ? 32'h0 : tbl[i-1].pc;
            waits = tbl[i].w;
            run_instr(fa, tbl[i].ma, tbl[i].isw, tbl[i].wd, cyc);
            chk({tbl[i].name, "_cyc"}, cyc, tbl[i].cyc);
            chk({tbl[i].name, "_pc"}, pc_debug, tbl[i].pc);
            dbg_sel = tbl[i].r;
            #1;
            chk({tbl[i].name, "_reg"}, dbg_data, tbl[i].rv);
            if (tbl[i].isw) begin
                chk("wr_addr", last_wa, tbl[i].ma);
                chk("wr_data", last_wd, tbl[i].wd);
            end
        end
        waits = 0;

        // Halt opcode
        run_instr(32'h34, 0, 0, 0, cyc);
        chk("halt_cyc", cyc, 2);
        chk("halt_state", state_debug, 5);
        chk("halt_pc", pc_debug, 32'h38);
        chk("halt_ir", instruction_debug, 32'hFC000000);
        bad = 0;
        repeat (20) begin
            @(posedge Clk); #1;
            if (!halt || mem_req || pc_debug != 32'h38) bad++;
        end
        chk("halt_hold", bad, 0);
        dbg_sel = 5'd4;
        #1;
        chk("halt_r4", dbg_data, 2);

        // Unsupported funct halts after EXEC
        prog[0] = 32'h00000003;
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        #1;
        dbg_sel = 5'd2;
        #1;
        chk("rst_r2", dbg_data, 0);
        run_instr(32'h0, 0, 0, 0, cyc);
        chk("badfn_cyc", cyc, 3);
        chk("badfn_halt", halt, 1);
        chk("badfn_pc", pc_debug, 32'h4);
        chk("badfn_req", mem_req, 0);

        // Reset asserted during a stalled sw
        prog[0] = 32'hAC020008;
        waits = 5;
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        cyc = 0;
        while (state_debug != 3'd3 && cyc < 40) begin
            @(posedge Clk); #1;
            cyc++;
        end
        chk("sw_reached_mem", state_debug, 3);
        @(posedge Clk); #1;
        chk("sw_wait_req", mem_req, 1);
        chk("sw_wait_we", mem_we, 1);
        chk("sw_wait_addr", mem_addr, 8);
        wr0 = n_wr;
        Rst = 1'b1;
        #1;
        chk("arst_state", state_debug, 0);
        chk("arst_pc", pc_debug, 0);
        chk("arst_req", mem_req, 0);
        chk("arst_we", mem_we, 0);
        repeat (2) @(posedge Clk);
        #1;
        chk("arst_nowr", n_wr, wr0);
        Rst = 1'b0;
        #1;
        chk("arst_rel_req", mem_req, 1);
        chk("arst_rel_addr", mem_addr, 0);
        chk("arst_rel_state", state_debug, 0);
        repeat (3) @(posedge Clk);
        #1;
        chk("arst_nowr2", n_wr, wr0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
